// File: rtl/jump_index_encoder.sv
// jump_index_encoder
//   Recovers the 26-bit J-type index from a 32-bit byte jump target and
//   assembles a J/JAL instruction word. This undoes the core's target
//   formation {pc_hi, 2'b00, index - INDEX_BIAS}. The block has two
//   pipeline stages with valid/ready handshakes on both sides.
//
// Optional feature macro: JUMP_INDEX_ENCODER_ERRCNT_EN
//   When defined, adds err_count, a saturating count of output transfers
//   that carried a nonzero error code.
//
// Ports
//   clk, rst    clock; synchronous active-high reset
//   in_valid    request valid
//   in_ready    block can accept a request this cycle
//   in_target   byte jump target
//   in_pc_hi    PC[31:28] of the jump slot
//   in_link     1 = JAL, 0 = J
//   out_valid   result valid
//   out_ready   consumer accepts the result
//   out_instr   {opcode, index}, or 0 when out_err != 0
//   out_index   recovered index
//   out_err     bit0 = region mismatch, bit1 = target[27:26] nonzero
//   err_count   saturating error counter (macro builds only)
module jump_index_encoder #(
  parameter logic [25:0] INDEX_BIAS = 26'h0100000,
  parameter logic [5:0]  OP_J       = 6'b000010,
  parameter logic [5:0]  OP_JAL     = 6'b000011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_target,
  input  logic [3:0]  in_pc_hi,
  input  logic        in_link,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [25:0] out_index,
  output logic [1:0]  out_err
`ifdef JUMP_INDEX_ENCODER_ERRCNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  // Stage 1: check register
  logic        s1_valid_q, s1_valid_d;
  logic [25:0] s1_idx_q,   s1_idx_d;
  logic [1:0]  s1_err_q,   s1_err_d;
  logic        s1_link_q,  s1_link_d;

  // Stage 2: output register
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] instr_q,    instr_d;
  logic [25:0] index_q,    index_d;
  logic [1:0]  err_q,      err_d;

  logic        s2_load;
  logic [25:0] idx_sum;

  // The carry out of bit 25 is intentionally dropped: a wrapped index is legal.
  assign idx_sum = in_target[25:0] + INDEX_BIAS;

  // Stage 2 can load when it is empty or being drained this cycle.
  assign s2_load = !s2_valid_q || out_ready;

  // Both handshakes are masked while rst is high. This prevents an output
  // transfer in the reset cycle, because the flops are only cleared at the
  // edge.
  assign in_ready  = !rst && (!s1_valid_q || s2_load);
  assign out_valid = !rst && s2_valid_q;
  assign out_instr = instr_q;
  assign out_index = index_q;
  assign out_err   = err_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_idx_d   = s1_idx_q;
    s1_err_d   = s1_err_q;
    s1_link_d  = s1_link_q;
    s2_valid_d = s2_valid_q;
    instr_d    = instr_q;
    index_d    = index_q;
    err_d      = err_q;

    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        index_d = s1_idx_q;
        err_d   = s1_err_q;
        instr_d = (s1_err_q == 2'b00) ? {(s1_link_q ? OP_JAL : OP_J), s1_idx_q} : 32'h0;
      end
    end

    // in_ready already implies stage 1 is empty or moving into stage 2.
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_idx_d  = idx_sum;
        s1_err_d  = {in_target[27:26] != 2'b00, in_target[31:28] != in_pc_hi};
        s1_link_d = in_link;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s1_err_q   <= '0;
      s1_link_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      instr_q    <= '0;
      index_q    <= '0;
      err_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_idx_q   <= s1_idx_d;
      s1_err_q   <= s1_err_d;
      s1_link_q  <= s1_link_d;
      s2_valid_q <= s2_valid_d;
      instr_q    <= instr_d;
      index_q    <= index_d;
      err_q      <= err_d;
    end
  end

`ifdef JUMP_INDEX_ENCODER_ERRCNT_EN
  logic [15:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (out_valid && out_ready && (err_q != 2'b00) && (err_count_q != 16'hFFFF))
      err_count_d = err_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_count_q <= '0;
    else     err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_jump_index_encoder.sv
module tb_jump_index_encoder;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_target;
  logic [3:0]  in_pc_hi;
  logic        in_link;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [25:0] out_index;
  logic [1:0]  out_err;
`ifdef JUMP_INDEX_ENCODER_ERRCNT_EN
  logic [15:0] err_count;
`endif

  jump_index_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_target (in_target),
    .in_pc_hi  (in_pc_hi),
    .in_link   (in_link),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_index (out_index),
    .out_err   (out_err)
`ifdef JUMP_INDEX_ENCODER_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [25:0] idx;
    logic [1:0]  err;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: sample mid-cycle; a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        fails++;
        $display("FAIL unexpected_output: got instr %h index %h err %b expected none",
                 out_instr, out_index, out_err);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_instr", out_instr, e.instr);
        chk("out_index", {6'd0, out_index}, {6'd0, e.idx});
        chk("out_err",   {30'd0, out_err}, {30'd0, e.err});
        if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
      end
    end
  end

  // Called at #1 after a rising edge. Holds the request until it is accepted.
  task automatic send(input logic [31:0] t, input logic [3:0] pc, input logic lk,
                      input logic [31:0] ei, input logic [25:0] ex, input logic [1:0] ee,
                      input bit lat);
    int n;
    exp_t e;
    in_valid = 1'b1; in_target = t; in_pc_hi = pc; in_link = lk;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) begin
      total++; fails++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 for target %h", t);
    end else begin
      e.instr = ei; e.idx = ex; e.err = ee; e.cyc = cyc; e.lat = lat;
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++; fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [31:0] snap_instr;
  logic [25:0] snap_idx;
  logic [1:0]  snap_err;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_target = '0; in_pc_hi = '0; in_link = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_index", {6'd0, out_index}, 32'd0);
    chk("rst_out_err",   {30'd0, out_err}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Directed streaming vectors with out_ready held high
    send(32'h00400000, 4'h0, 1'b0, 32'h08500000, 26'h0500000, 2'b00, 1'b1);
    send(32'h00400000, 4'h0, 1'b1, 32'h0C500000, 26'h0500000, 2'b00, 1'b1);
    send(32'h03F00000, 4'h0, 1'b0, 32'h08000000, 26'h0000000, 2'b00, 1'b1);
    send(32'h30001234, 4'h3, 1'b1, 32'h0C101234, 26'h0101234, 2'b00, 1'b1);
    send(32'h03EFFFFC, 4'h0, 1'b0, 32'h0BFFFFFC, 26'h3FFFFFC, 2'b00, 1'b1);
    send(32'h10400000, 4'h0, 1'b0, 32'h00000000, 26'h0500000, 2'b01, 1'b1);
    send(32'h04000000, 4'h0, 1'b1, 32'h00000000, 26'h0100000, 2'b10, 1'b1);
    drain();
`ifdef JUMP_INDEX_ENCODER_ERRCNT_EN
    chk("err_count_2", {16'd0, err_count}, 32'd2);
`endif
    send(32'h14000000, 4'h0, 1'b0, 32'h00000000, 26'h0100000, 2'b11, 1'b1);
    drain();

    // Backpressure: two requests are accepted, then the third stalls
    out_ready = 1'b0;
    send(32'h00000010, 4'h0, 1'b0, 32'h08100010, 26'h0100010, 2'b00, 1'b0);
    send(32'h20000020, 4'h2, 1'b1, 32'h0C100020, 26'h0100020, 2'b00, 1'b0);
    in_valid = 1'b1; in_target = 32'h00000030; in_pc_hi = 4'h0; in_link = 1'b0;
    @(negedge clk);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    snap_instr = out_instr; snap_idx = out_index; snap_err = out_err;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_stable_instr", out_instr, snap_instr);
      chk("bp_stable_index", {6'd0, out_index}, {6'd0, snap_idx});
      chk("bp_stable_err", {30'd0, out_err}, {30'd0, snap_err});
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    begin
      exp_t e;
      e.instr = 32'h08100030; e.idx = 26'h0100030; e.err = 2'b00; e.cyc = cyc; e.lat = 1'b0;
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
`ifdef JUMP_INDEX_ENCODER_ERRCNT_EN
    chk("err_count_3", {16'd0, err_count}, 32'd3);
`endif

    // Reset with both stages full: the in-flight results must vanish
    out_ready = 1'b0;
    send(32'h00000040, 4'h0, 1'b0, 32'h08100040, 26'h0100040, 2'b00, 1'b0);
    send(32'h10000050, 4'h0, 1'b0, 32'h00000000, 26'h0100050, 2'b01, 1'b0);
    rst = 1'b1;
    q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_cycle_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_out_err", {30'd0, out_err}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
`ifdef JUMP_INDEX_ENCODER_ERRCNT_EN
    chk("err_count_rst", {16'd0, err_count}, 32'd0);
`endif
    send(32'h00000004, 4'h0, 1'b1, 32'h0C100004, 26'h0100004, 2'b00, 1'b1);
    drain();
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
